spi_master: RTL and testbench

SPI master (mode 0: CPOL=0, CPHA=0, MSB first) that drives CS_L, SCLK and MOSI and samples MISO, all in the system clock domain. It is the initiator counterpart of the team's SPI slave peripheral, used to drive external SPI devices and to exercise the slave in loopback. The user side is a valid/ready word interface: one word is sent and one word is received per transaction.

---
 rtl/spi_master.sv | 139 +++++++++++++
 tb/tb_spi_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: one WIDTH-bit word out on MOSI and one in from MISO per
// transaction, MSB first, with SCLK = clk / (2*CLK_DIV).
module spi_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             CS_L,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS     = BW'(WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_e;

  state_e           state_q;
  logic [DW-1:0]    divCnt_q;
  logic [BW-1:0]    bitCnt_q;
  logic [WIDTH-1:0] txShift_q;
  logic [WIDTH-1:0] rxShift_q;
  logic [WIDTH-1:0] rxData_q;
  logic             rxValid_q;
  logic             txReady_q;
  logic             busy_q;
  logic             csL_q;
  logic             sclk_q;
  logic             mosi_q;
  logic             divDone;

  assign divDone = (divCnt_q == DIV_LAST);

  // Every state except IDLE lasts a whole number of CLK_DIV-cycle slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      divCnt_q  <= '0;
      bitCnt_q  <= '0;
      txShift_q <= '0;
      rxShift_q <= '0;
      rxData_q  <= '0;
      rxValid_q <= 1'b0;
      txReady_q <= 1'b1;
      busy_q    <= 1'b0;
      csL_q     <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      rxValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid && txReady_q) begin
            txShift_q <= tx_data;
            rxShift_q <= '0;
            bitCnt_q  <= '0;
            divCnt_q  <= '0;
            csL_q     <= 1'b0;
            mosi_q    <= tx_data[WIDTH-1];
            txReady_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          if (divDone) begin
            divCnt_q <= '0;
            state_q  <= XFER;
          end else begin
            divCnt_q <= divCnt_q + 1'b1;
          end
        end
        XFER: begin
          if (divDone) begin
            divCnt_q <= '0;
            if (!sclk_q) begin
              sclk_q    <= 1'b1;
              rxShift_q <= {rxShift_q[WIDTH-2:0], MISO};
              bitCnt_q  <= bitCnt_q + 1'b1;
            end else begin
              sclk_q <= 1'b0;
              // The last falling edge ends the word instead of presenting a new bit.
              if (bitCnt_q < BITS) begin
                txShift_q <= {txShift_q[WIDTH-2:0], 1'b0};
                mosi_q    <= txShift_q[WIDTH-2];
              end else begin
                mosi_q  <= 1'b0;
                state_q <= HOLD;
              end
            end
          end else begin
            divCnt_q <= divCnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (divDone) begin
            divCnt_q  <= '0;
            csL_q     <= 1'b1;
            rxData_q  <= rxShift_q;
            rxValid_q <= 1'b1;
            state_q   <= GAP;
          end else begin
            divCnt_q <= divCnt_q + 1'b1;
          end
        end
        GAP: begin
          if (divDone) begin
            divCnt_q  <= '0;
            txReady_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            divCnt_q <= divCnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready = txReady_q;
  assign rx_data  = rxData_q;
  assign rx_valid = rxValid_q;
  assign busy     = busy_q;
  assign CS_L     = csL_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance at CLK_DIV=2 (model slave or
// loopback on MISO) and one at CLK_DIV=1 in loopback.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] txData0 = 8'h00, txData1 = 8'h00;
  logic       txValid0 = 1'b0, txValid1 = 1'b0;
  logic       txReady0, txReady1, rxValid0, rxValid1, busy0, busy1;
  logic       csL0, csL1, sclk0, sclk1, mosi0, mosi1, miso0, miso1;
  logic [7:0] rxData0, rxData1;

  logic       loop0 = 1'b0;
  logic [7:0] slaveWord = 8'h3C;
  logic [7:0] slvSr = 8'h00;
  logic       slvSclkPrev = 1'b0;

  int checks = 0;
  int failures = 0;

  logic sel = 1'b0;
  logic holdValid = 1'b0;
  logic [7:0] curWord = 8'h00, nextWord = 8'h00;
  int pulseAt = -10, changeAt = -10;

  int kRxValid, validPulses, csLowCnt, csHighCnt, rises, readyAt, waitCycles;
  int hiMin, hiMax, loMin, loMax;
  logic [7:0] mosiCap, rxCap;

  wire       mCs     = sel ? csL1 : csL0;
  wire       mSclk   = sel ? sclk1 : sclk0;
  wire       mMosi   = sel ? mosi1 : mosi0;
  wire       mReady  = sel ? txReady1 : txReady0;
  wire       mRxValid = sel ? rxValid1 : rxValid0;
  wire [7:0] mRxData = sel ? rxData1 : rxData0;

  always #5 clk = ~clk;

  spi_master #(.WIDTH(8), .CLK_DIV(2)) u_dut (
    .clk(clk), .rst(rst), .tx_data(txData0), .tx_valid(txValid0),
    .tx_ready(txReady0), .rx_data(rxData0), .rx_valid(rxValid0), .busy(busy0),
    .CS_L(csL0), .SCLK(sclk0), .MOSI(mosi0), .MISO(miso0)
  );

  spi_master #(.WIDTH(8), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(txData1), .tx_valid(txValid1),
    .tx_ready(txReady1), .rx_data(rxData1), .rx_valid(rxValid1), .busy(busy1),
    .CS_L(csL1), .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1)
  );

  // Mode-0 slave: reloads while deselected, shifts one clk after each SCLK fall.
  always @(posedge clk) begin
    slvSclkPrev <= sclk0;
    if (csL0) slvSr <= slaveWord;
    else if (slvSclkPrev && !sclk0) slvSr <= {slvSr[6:0], 1'b0};
  end

  assign miso0 = loop0 ? mosi0 : slvSr[7];
  assign miso1 = mosi1;

  task automatic setTx(input logic v, input logic [7:0] d);
    if (sel) begin txValid1 = v; txData1 = d; end
    else begin txValid0 = v; txData0 = d; end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic applyStimulus(input logic [7:0] word);
    curWord = word;
    setTx(1'b1, word);
    waitCycles = 0;
    while (!mReady && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    checks++;
    if (!mReady) begin
      failures++;
      $display("[TB] FAIL accept_timeout: tx_ready=%0b required 1", mReady);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Observation k reflects the state after the k-th edge following accept.
  task automatic watchTxn(input int limit);
    logic sclkPrev;
    int run;
    kRxValid = -1; validPulses = 0; csLowCnt = 0; csHighCnt = 0; rises = 0;
    readyAt = -1; hiMin = 999; hiMax = 0; loMin = 999; loMax = 0;
    mosiCap = 8'h00; rxCap = 8'h00; sclkPrev = 1'b0; run = 0;
    for (int k = 0; k <= limit; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin
        if (holdValid) setTx(1'b1, nextWord);
        else setTx(1'b0, curWord);
      end
      if (k == pulseAt) setTx(1'b1, 8'h11);
      if (k == pulseAt + 1) setTx(1'b0, 8'h11);
      if (k == changeAt) setTx(1'b0, 8'hFF);
      if (!mCs) csLowCnt++;
      else if (k > 0) csHighCnt++;
      if (mRxValid) begin
        validPulses++;
        if (kRxValid < 0) begin kRxValid = k; rxCap = mRxData; end
      end
      if (mSclk && !sclkPrev) begin
        mosiCap = {mosiCap[6:0], mMosi};
        rises++;
      end
      if (mSclk != sclkPrev) begin
        if (sclkPrev) begin
          if (run < hiMin) hiMin = run;
          if (run > hiMax) hiMax = run;
        end else if (rises >= 2) begin
          if (run < loMin) loMin = run;
          if (run > loMax) loMax = run;
        end
        run = 0;
      end
      run++;
      sclkPrev = mSclk;
      if (k > 0 && mReady) begin
        readyAt = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int bad, vld;
    bad = 0; vld = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (csL0 !== 1'b1 || sclk0 !== 1'b0 || mosi0 !== 1'b0 || txReady0 !== 1'b1 ||
          busy0 !== 1'b0 || rxData0 !== 8'h00) bad++;
      if (csL1 !== 1'b1 || sclk1 !== 1'b0 || txReady1 !== 1'b1 || busy1 !== 1'b0) bad++;
      if (rxValid0 !== 1'b0 || rxValid1 !== 1'b0) vld++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL reset_idle_outputs: bad cycles=%0d required 0", bad);
    end
    checks++;
    if (vld !== 0) begin
      failures++;
      $display("[TB] FAIL reset_no_rx_valid: pulses=%0d required 0", vld);
    end
  endtask

  task automatic test_basic;
    sel = 1'b0; loop0 = 1'b0; slaveWord = 8'h3C; holdValid = 1'b0;
    applyStimulus(8'hA5);
    watchTxn(100);
    checks++;
    if (mosiCap !== 8'hA5) begin failures++; $display("[TB] FAIL basic_mosi: got %h required a5", mosiCap); end
    checks++;
    if (rises !== 8) begin failures++; $display("[TB] FAIL basic_rises: got %0d required 8", rises); end
    checks++;
    if (rxCap !== 8'h3C) begin failures++; $display("[TB] FAIL basic_rx: got %h required 3c", rxCap); end
    checks++;
    if (kRxValid !== 36) begin failures++; $display("[TB] FAIL basic_rx_latency: got %0d required 36", kRxValid); end
    checks++;
    if (validPulses !== 1) begin failures++; $display("[TB] FAIL basic_pulses: got %0d required 1", validPulses); end
    checks++;
    if (csLowCnt !== 36) begin failures++; $display("[TB] FAIL basic_cs_low: got %0d required 36", csLowCnt); end
    checks++;
    if (readyAt !== 38) begin failures++; $display("[TB] FAIL basic_ready: got %0d required 38", readyAt); end
    @(negedge clk);
    checks++;
    if (rxData0 !== 8'h3C || busy0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_hold: rx=%h busy=%0b required 3c/0", rxData0, busy0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [3];
    int prevHigh;
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h81;
    sel = 1'b0; loop0 = 1'b1; prevHigh = 0;
    for (int i = 0; i < 3; i++) begin
      holdValid = (i < 2);
      nextWord = (i < 2) ? words[i+1] : words[i];
      applyStimulus(words[i]);
      if (i > 0) begin
        checks++;
        if (prevHigh < 2) begin failures++; $display("[TB] FAIL b2b_cs_gap%0d: got %0d required >=2", i, prevHigh); end
      end
      watchTxn(100);
      prevHigh = csHighCnt;
      checks++;
      if (rxCap !== words[i]) begin failures++; $display("[TB] FAIL b2b_rx%0d: got %h required %h", i, rxCap, words[i]); end
      checks++;
      if (hiMin !== 2 || hiMax !== 2 || loMin !== 2 || loMax !== 2) begin
        failures++;
        $display("[TB] FAIL b2b_phase%0d: hi %0d..%0d lo %0d..%0d required 2", i, hiMin, hiMax, loMin, loMax);
      end
    end
    holdValid = 1'b0;
    checks++;
    if (prevHigh !== 3) begin failures++; $display("[TB] FAIL b2b_final_gap: got %0d required 3", prevHigh); end
  endtask

  task automatic test_clkdiv1;
    sel = 1'b1; holdValid = 1'b0;
    applyStimulus(8'h5A);
    watchTxn(60);
    checks++;
    if (hiMin !== 1 || hiMax !== 1 || loMin !== 1 || loMax !== 1) begin
      failures++;
      $display("[TB] FAIL div1_phase: hi %0d..%0d lo %0d..%0d required 1", hiMin, hiMax, loMin, loMax);
    end
    checks++;
    if (rxCap !== 8'h5A) begin failures++; $display("[TB] FAIL div1_rx: got %h required 5a", rxCap); end
    checks++;
    if (mosiCap !== 8'h5A) begin failures++; $display("[TB] FAIL div1_mosi: got %h required 5a", mosiCap); end
    checks++;
    if (readyAt !== 19) begin failures++; $display("[TB] FAIL div1_ready: got %0d required 19", readyAt); end
    checks++;
    if (kRxValid !== 18 || csLowCnt !== 18) begin
      failures++;
      $display("[TB] FAIL div1_timing: valid@%0d cslow=%0d required 18/18", kRxValid, csLowCnt);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic prev;
    int n, vld;
    sel = 1'b0; loop0 = 1'b1; holdValid = 1'b0;
    applyStimulus(8'hC6);
    setTx(1'b0, 8'hC6);
    n = 0; prev = 1'b0; rises = 0;
    while (rises < 3 && n < 80) begin
      @(negedge clk);
      n++;
      if (sclk0 && !prev) rises++;
      prev = sclk0;
    end
    checks++;
    if (rises !== 3) begin failures++; $display("[TB] FAIL rstmid_rises: got %0d required 3", rises); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (csL0 !== 1'b1 || sclk0 !== 1'b0 || mosi0 !== 1'b0 || txReady0 !== 1'b1 ||
        busy0 !== 1'b0 || rxValid0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_outputs: cs=%0b sclk=%0b mosi=%0b rdy=%0b busy=%0b vld=%0b required 1/0/0/1/0/0",
               csL0, sclk0, mosi0, txReady0, busy0, rxValid0);
    end
    vld = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rxValid0) vld++;
    end
    checks++;
    if (vld !== 0) begin failures++; $display("[TB] FAIL rstmid_no_valid: got %0d required 0", vld); end
    applyStimulus(8'h96);
    watchTxn(100);
    checks++;
    if (rxCap !== 8'h96 || mosiCap !== 8'h96) begin
      failures++;
      $display("[TB] FAIL rstmid_next: rx=%h mosi=%h required 96/96", rxCap, mosiCap);
    end
  endtask

  task automatic test_ignore_busy;
    int extra;
    sel = 1'b0; loop0 = 1'b1; holdValid = 1'b0;
    pulseAt = 5; changeAt = 10;
    applyStimulus(8'hC3);
    watchTxn(100);
    pulseAt = -10; changeAt = -10;
    checks++;
    if (mosiCap !== 8'hC3 || rxCap !== 8'hC3) begin
      failures++;
      $display("[TB] FAIL busy_word: mosi=%h rx=%h required c3/c3", mosiCap, rxCap);
    end
    checks++;
    if (validPulses !== 1 || readyAt !== 38) begin
      failures++;
      $display("[TB] FAIL busy_single: pulses=%0d ready@%0d required 1/38", validPulses, readyAt);
    end
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy0 || !csL0 || rxValid0) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("[TB] FAIL busy_no_second: active cycles=%0d required 0", extra); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_clkdiv1;
    test_reset_mid;
    test_ignore_busy;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
